// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter and single-outstanding instruction fetch.
// Fetches one word over a req/ack handshake, holds it for execution, then
// selects the next PC from the branch/jump controls on the retiring edge.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (trap to HALT on a misaligned
// taken target instead of masking the low address bits).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_FETCH | request outstanding at pc, waiting for imem_ack
// S_EXEC  | instruction held and valid, retires when stall is low
// S_HALT  | misaligned target trapped, frozen until rst
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  input  logic [31:0] imm_ext,
  output logic [31:0] retired_count,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] retired_q, retired_d;
  // Low for the first cycle after reset so the request only rises once reset
  // has been released, and so a late ack from an abandoned fetch is dropped.
  logic        req_en_q, req_en_d;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
`endif

  logic        pc_src;
  logic [31:0] target;
  logic [31:0] pc_next;

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      retired_q     <= 32'd0;
      req_en_q      <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      retired_q     <= retired_d;
      req_en_q      <= req_en_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  // Next-state and next-PC selection; controls are only looked at on retire
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    retired_d     = retired_q;
    req_en_d      = req_en_q;
    pc_src        = 1'b0;
    target        = pc_q;
    pc_next       = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d    = misalign_q;
`endif
    case (state_q)
      S_FETCH: begin
        req_en_d = 1'b1;
        if (req_en_q && imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          pc_src  = (branch & zero) | jump;
          target  = pc_q + imm_ext;
          pc_next = pc_src ? target : (pc_q + 32'd4);
          instr_d       = NOP_INSTR;
          instr_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (pc_src && (target[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            pc_d      = {pc_next[31:2], 2'b00};
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
          end
`else
          pc_d      = {pc_next[31:2], 2'b00};
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
`endif
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    imem_req      = (state_q == S_FETCH) && req_en_q;
    imem_addr     = pc_q;
    instr         = instr_q;
    instr_valid   = instr_valid_q;
    pc            = pc_q;
    pc_plus4      = pc_q + 32'd4;
    retired_count = retired_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_err  = misalign_q;
`else
    misalign_err  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        branch;
  logic        jump;
  logic        zero;
  logic [31:0] imm_ext;
  logic [31:0] retired_count;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  // Reference: what the fetch unit should be doing, as plain variables
  bit          m_started;  // request allowed (one cycle after reset)
  bit          m_holding;  // an instruction has been fetched and not retired
  bit          m_halted;
  logic [31:0] m_pc;
  logic [31:0] m_word;
  logic [31:0] m_retired;
  bit          m_err;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .stall         (stall),
    .branch        (branch),
    .jump          (jump),
    .zero          (zero),
    .imm_ext       (imm_ext),
    .retired_count (retired_count),
    .misalign_err  (misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit exp_req;
    exp_req = m_started && !m_holding && !m_halted;
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_holding});
    chk("instr", instr, m_holding ? m_word : NOP);
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("retired", retired_count, m_retired);
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
  endtask

  // Advance the reference by one rising edge using the inputs being driven
  task automatic model_edge();
    logic        take;
    logic [31:0] tgt;
    if (rst) begin
      m_started = 1'b0; m_holding = 1'b0; m_halted = 1'b0;
      m_pc = 32'd0; m_word = NOP; m_retired = 32'd0; m_err = 1'b0;
    end else if (m_halted) begin
      // frozen
    end else if (!m_holding) begin
      if (!m_started) m_started = 1'b1;
      else if (imem_ack) begin
        m_holding = 1'b1;
        m_word    = imem_rdata;
      end
    end else if (!stall) begin
      take = (branch && zero) || jump;
      tgt  = m_pc + imm_ext;
      m_holding = 1'b0;
      if (TRAP && take && (tgt % 4 != 0)) begin
        m_halted = 1'b1;
        m_err    = 1'b1;
      end else begin
        m_pc      = (take ? tgt : m_pc + 32'd4) & 32'hFFFF_FFFC;
        m_retired = m_retired + 32'd1;
      end
    end
  endtask

  task automatic cyc();
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    imem_ack = 1'b0; stall = 1'b0; branch = 1'b0; jump = 1'b0;
    zero = 1'b0; imm_ext = 32'd0;
  endtask

  // One instruction from an idle request: ack after ack_dly cycles, stall for
  // stall_n cycles, then retire with the given controls.
  task automatic run_instr(input int ack_dly, input int stall_n, input logic br,
                           input logic jp, input logic z, input logic [31:0] imm);
    imem_rdata = $urandom;
    for (int i = 0; i < ack_dly; i++) cyc();
    imem_ack = 1'b1;
    cyc();
    imem_ack = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < stall_n; i++) cyc();
    stall = 1'b0; branch = br; jump = jp; zero = z; imm_ext = imm;
    cyc();
    clear_inputs();
  endtask

  initial begin
    logic [31:0] r0;
    logic [31:0] p0;
    rst = 1'b1;
    imem_rdata = 32'd0;
    clear_inputs();
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;

    // Reset values and request timing
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    cyc();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("second_addr", imem_addr, 32'h4);
    chk("retired_one", retired_count, 32'd1);

    // Taken and not-taken beq at 0x10
    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 32'hC);
    chk("pc_at_10", pc, 32'h10);
    run_instr(0, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    chk("beq_taken", imem_addr, 32'h08);
    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 32'h8);
    run_instr(0, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8);
    chk("beq_not_taken", imem_addr, 32'h14);

    // jal at 0x20
    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 32'hC);
    imem_ack = 1'b1; imem_rdata = 32'h1000_006F;
    cyc();
    imem_ack = 1'b0;
    chk("jal_pc_plus4", pc_plus4, 32'h24);
    jump = 1'b1; imm_ext = 32'h100;
    cyc();
    clear_inputs();
    chk("jal_target", pc, 32'h120);

    // Ack delay 3 and stall 2
    r0 = retired_count;
    run_instr(3, 2, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("delay_retire", retired_count, r0 + 32'd1);

    // Reset during an outstanding fetch with a late ack
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    chk("rst_abandon_req", {31'd0, imem_req}, 32'd0);
    cyc();
    imem_ack = 1'b0;
    chk("late_ack_ignored", {31'd0, instr_valid}, 32'd0);
    chk("rst_abandon_pc", pc, 32'd0);
    cyc();

    // Misaligned jump target
    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 32'h40);
    p0 = pc;
    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 32'h2);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("trap_err", {31'd0, misalign_err}, 32'd1);
    chk("trap_pc", pc, p0);
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    imem_ack = 1'b0;
    chk("trap_req_low", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
`else
    chk("mask_pc", pc, p0);
    chk("mask_req", {31'd0, imem_req}, 32'd1);
`endif

    // PC wrap
    p0 = pc;
    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC - p0);
    chk("pc_top", pc, 32'hFFFF_FFFC);
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("pc_wrap", pc, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 99) < 2);
      imem_ack   = $urandom_range(0, 1);
      imem_rdata = $urandom;
      stall      = ($urandom_range(0, 9) < 3);
      branch     = $urandom_range(0, 1);
      jump       = ($urandom_range(0, 3) == 0);
      zero       = $urandom_range(0, 1);
      imm_ext    = ($urandom_range(0, 9) == 0) ? $urandom
                                               : ($urandom & 32'h0000_0FFC) - 32'h800;
      cyc();
    end
    clear_inputs();
    rst = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
